// File: rtl/axim_pkg.sv
// Shared sizing constants for the byte-wide AXI4-Stream serializer.
package axim_pkg;
   localparam int DATA_W = 8;
   localparam int BEATS  = 8;
   localparam int WORD_W = DATA_W * BEATS;
   localparam int CNT_W  = $clog2(BEATS + 1);
endpackage

// File: rtl/axi_stream_master.sv
// Parallel-to-serial AXI4-Stream source: one word in, BEATS beats out, LSB beat first.
// Optional feature macro: AXIM_LOAD_ACK_EN adds the registered load_ack pulse output.
module axi_stream_master
   import axim_pkg::*;
#(
   parameter int DATA_W = axim_pkg::DATA_W,
   parameter int BEATS  = axim_pkg::BEATS
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [DATA_W*BEATS-1:0] data_in,
   input  logic                    we,
   output logic [DATA_W-1:0]       data,
   output logic                    valid,
   input  logic                    ready,
`ifdef AXIM_LOAD_ACK_EN
   output logic                    load_ack,
`endif
   output logic                    last
);

   localparam int IN_W     = DATA_W * BEATS;
   localparam int CNT_BITS = $clog2(BEATS + 1);

   logic [IN_W-1:0]     data_buff_q, data_buff_d;
   logic [CNT_BITS-1:0] buff_count_q, buff_count_d;
   logic                load_go;
   logic                beat_go;

   assign data  = data_buff_q[DATA_W-1:0];
   assign valid = (buff_count_q != '0);
   assign last  = (buff_count_q == CNT_BITS'(1));

   // A load is only taken when empty, so the edge finishing the last beat never reloads.
   always_comb begin
      data_buff_d  = data_buff_q;
      buff_count_d = buff_count_q;
      load_go      = we && (buff_count_q == '0);
      beat_go      = valid && ready;
      if (load_go) begin
         data_buff_d  = data_in;
         buff_count_d = CNT_BITS'(BEATS);
      end else if (beat_go) begin
         data_buff_d  = data_buff_q >> DATA_W;
         buff_count_d = buff_count_q - CNT_BITS'(1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         data_buff_q  <= '0;
         buff_count_q <= '0;
      end else begin
         data_buff_q  <= data_buff_d;
         buff_count_q <= buff_count_d;
      end
   end

`ifdef AXIM_LOAD_ACK_EN
   logic load_ack_q, load_ack_d;

   always_comb begin
      load_ack_d = load_go;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         load_ack_q <= 1'b0;
      end else begin
         load_ack_q <= load_ack_d;
      end
   end

   assign load_ack = load_ack_q;
`endif

endmodule

// File: tb/tb_axi_stream_master.sv
// Directed bench for axi_stream_master: expected beats are queued at load time and
// popped whenever the DUT completes a handshake. Define AXIM_LOAD_ACK_EN to cover load_ack.
module tb_axi_stream_master;

   logic        clk;
   logic        reset;
   logic [63:0] data_in;
   logic        we;
   logic [7:0]  data;
   logic        valid;
   logic        ready;
   logic        last;
`ifdef AXIM_LOAD_ACK_EN
   logic        load_ack;
`endif

   int unsigned checks = 0;
   int unsigned errors = 0;
   logic [8:0]  exp_q[$];

   axi_stream_master #(.DATA_W(8), .BEATS(8)) dut (
      .clk     (clk),
      .reset   (reset),
      .data_in (data_in),
      .we      (we),
      .data    (data),
      .valid   (valid),
      .ready   (ready),
`ifdef AXIM_LOAD_ACK_EN
      .load_ack(load_ack),
`endif
      .last    (last)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, observed timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Queue the beats a word should produce, LSB byte first, last flag on the final one.
   task automatic push_word(input logic [63:0] w);
      logic [63:0] t;
      t = w;
      for (int i = 0; i < 8; i++) begin
         exp_q.push_back({(i == 7), t[7:0]});
         t = t >> 8;
      end
   endtask

   // One clock: sample at negedge; a beat with valid&&ready is taken at the next posedge.
   task automatic tick();
      logic [8:0] e;
      @(negedge clk);
      if (valid && ready) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_beat", {56'd0, data}, 64'hDEAD);
         end else begin
            e = exp_q.pop_front();
            chk("beat_data", {56'd0, data}, {56'd0, e[7:0]});
            chk("beat_last", {63'd0, last}, {63'd0, e[8]});
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic load(input logic [63:0] w);
      data_in = w;
      we      = 1'b1;
      push_word(w);
      tick();
      we      = 1'b0;
   endtask

   task automatic chk_empty(input string tag);
      chk({tag, "_valid"}, {63'd0, valid}, 64'd0);
      chk({tag, "_data"},  {56'd0, data},  64'd0);
      chk({tag, "_last"},  {63'd0, last},  64'd0);
      chk({tag, "_queue"}, 64'(exp_q.size()), 64'd0);
   endtask

   initial begin
      reset   = 1'b1;
      we      = 1'b0;
      ready   = 1'b1;
      data_in = '0;
      #2;
      chk_empty("reset");
`ifdef AXIM_LOAD_ACK_EN
      chk("reset_load_ack", {63'd0, load_ack}, 64'd0);
`endif
      tick();
      tick();
      reset = 1'b0;
      tick();

      // 1: full word at full rate
      load(64'h0807060504030201);
      chk("t1_valid_latency", {63'd0, valid}, 64'd1);
      repeat (8) tick();
      chk_empty("t1_end");

      // 2: backpressure after three beats
      load(64'h8877665544332211);
      repeat (3) tick();
      ready = 1'b0;
      repeat (5) begin
         tick();
         chk("t2_hold_data",  {56'd0, data},  64'h44);
         chk("t2_hold_valid", {63'd0, valid}, 64'd1);
         chk("t2_hold_last",  {63'd0, last},  64'd0);
      end
      ready = 1'b1;
      repeat (5) tick();
      chk_empty("t2_end");

      // 3: zero bytes are still sent
      load(64'h00000000D4C3B2A1);
      repeat (8) tick();
      chk_empty("t3_end");

      // 4: we held through the rest of a transfer, including the last-beat edge
      load(64'h8877665544332211);
      repeat (2) tick();
      data_in = 64'h8899AABBCCDDEEFF;
      we      = 1'b1;
      repeat (6) tick();
      we      = 1'b0;
      chk_empty("t4_end");
      tick();
      chk_empty("t4_idle");

      // 5: asynchronous reset mid-word
      load(64'h1122334455667788);
      repeat (3) tick();
      #2;
      reset = 1'b1;
      #1;
      chk_empty_reset: begin
         chk("t5_valid", {63'd0, valid}, 64'd0);
         chk("t5_data",  {56'd0, data},  64'd0);
         chk("t5_last",  {63'd0, last},  64'd0);
      end
      exp_q.delete();
      tick();
      reset = 1'b0;
      repeat (4) begin
         tick();
         chk("t5_post_valid", {63'd0, valid}, 64'd0);
      end

`ifdef AXIM_LOAD_ACK_EN
      // 6: load_ack pulses once per accepted load only
      load(64'h0102030405060708);
      chk("t6_ack_pulse", {63'd0, load_ack}, 64'd1);
      data_in = 64'hFFFF;
      we      = 1'b1;
      tick();
      chk("t6_ack_drop", {63'd0, load_ack}, 64'd0);
      repeat (6) begin
         tick();
         chk("t6_ack_ignored", {63'd0, load_ack}, 64'd0);
      end
      we = 1'b0;
      tick();
      chk("t6_ack_idle", {63'd0, load_ack}, 64'd0);
      chk_empty("t6_end");
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
